uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 8 +
 rtl/sync_fifo.sv | 39 +++
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 tb/tb_uart_rx_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver states and vote helper shared by the UART blocks
package uart_pkg;
   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, simultaneous push/pop allowed when full, no bypass when empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   // storage needs no reset; dout is masked while empty
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority vote feeding a receive FIFO
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int      CLKS_PER_BIT = 434,
   parameter int      DATA_BITS    = 8,
   parameter parity_t PARITY       = PAR_NONE,
   parameter int      STOP_BITS    = 1,
   parameter int      FIFO_DEPTH   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        input_serial,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_parity_err,
   output logic                        rx_frame_err,
   output logic                        overrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] MID       = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] MID_M1    = MID - CW'(1);
   localparam logic [CW-1:0] MID_P1    = MID + CW'(1);
   localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    DLAST     = 3'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);
   rx_state_t state, state_n;
   logic sync1, line, maj, at_dec, at_wrap, push, pop, full, empty, stop_idx, par_err, frm_err;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [1:0] vote;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS+1:0] head;
   assign at_dec  = cnt == MID_P1;
   assign at_wrap = cnt == LAST;
   assign maj     = maj3(vote[0], vote[1], line);
   assign pop     = rx_valid && rx_ready;
   assign rx_valid      = !empty;
   assign rx_data       = head[DATA_BITS+1:2];
   assign rx_parity_err = head[1];
   assign rx_frame_err  = head[0];
   // two-flop synchronizer, idles high
   always_ff @(posedge clk or posedge reset)
      if (reset) {line, sync1} <= 2'b11;
      else {line, sync1} <= {sync1, input_serial};
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= RX_IDLE;
      else state <= state_n;
   // next state; push fires at the last stop-bit decision so the next start edge is caught early
   always_comb begin
      state_n = state;
      push    = 1'b0;
      case (state)
         RX_IDLE:   if (!line) state_n = RX_START;
         RX_START:  if (at_dec && maj) state_n = RX_IDLE;
                    else if (at_wrap) state_n = RX_DATA;
         RX_DATA:   if (at_wrap && bit_idx == DLAST) state_n = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
         RX_PARITY: if (at_wrap) state_n = RX_STOP;
         RX_STOP:   if (at_dec && stop_idx == STOP_LAST) begin
                       state_n = RX_IDLE;
                       push    = 1'b1;
                    end
         default:   state_n = RX_IDLE;
      endcase
   end
   // bit timing, vote samples, shift register and error flags; the falling-edge cycle counts as 0
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt      <= '0;
         vote     <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         cnt <= (state_n == RX_IDLE) ? '0 : (state == RX_IDLE) ? CW'(1) : at_wrap ? '0 : cnt + CW'(1);
         if (cnt == MID_M1) vote[0] <= line;
         if (cnt == MID) vote[1] <= line;
         if (state == RX_IDLE) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
         end
         if (state == RX_DATA && at_dec) shreg[bit_idx] <= maj;
         if (state == RX_DATA && at_wrap) bit_idx <= (bit_idx == DLAST) ? '0 : bit_idx + 3'd1;
         if (state == RX_PARITY && at_dec) par_err <= ^shreg ^ maj ^ (PARITY == PAR_ODD);
         if (state == RX_STOP && at_dec && !maj) frm_err <= 1'b1;
         if (state == RX_STOP && at_wrap) stop_idx <= 1'b1;
         overrun <= push && full && !pop;
      end
   sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({shreg, par_err, frm_err | !maj}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks plus randomized frames checked against a queue model
module tb_uart_rx_fifo;
   import uart_pkg::*;
   localparam int CPB = 16, DEPTH = 4;
   typedef struct {logic [7:0] d; logic pe; logic fe;} ent_t;
   logic clk = 0, reset = 1, ser_n = 1, ser_e = 1, rdy_n = 0, rdy_e = 0, sel = 0;
   logic valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e, ov_n, ov_e, ovp_n = 0, ovp_e = 0;
   logic [7:0] data_n, data_e;
   logic [2:0] cnt_n, cnt_e;
   logic s_valid, s_perr, s_ferr, s_ov;
   logic [7:0] s_data;
   logic [2:0] s_count;
   int cmp = 0, bad = 0, exp_ov = 0, ovh_n = 0, ovr_n = 0, ovh_e = 0, ovr_e = 0;
   ent_t q[$];
   always #5 clk = ~clk;
   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_n (
      .clk(clk), .reset(reset), .input_serial(ser_n), .rx_valid(valid_n), .rx_ready(rdy_n), .rx_data(data_n),
      .rx_parity_err(perr_n), .rx_frame_err(ferr_n), .overrun(ov_n), .fifo_count(cnt_n));
   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_e (
      .clk(clk), .reset(reset), .input_serial(ser_e), .rx_valid(valid_e), .rx_ready(rdy_e), .rx_data(data_e),
      .rx_parity_err(perr_e), .rx_frame_err(ferr_e), .overrun(ov_e), .fifo_count(cnt_e));
   assign s_valid = sel ? valid_e : valid_n;
   assign s_data  = sel ? data_e : data_n;
   assign s_perr  = sel ? perr_e : perr_n;
   assign s_ferr  = sel ? ferr_e : ferr_n;
   assign s_ov    = sel ? ov_e : ov_n;
   assign s_count = sel ? cnt_e : cnt_n;
   always @(negedge clk) begin
      if (ov_n) ovh_n++;
      if (ov_n && !ovp_n) ovr_n++;
      if (ov_e) ovh_e++;
      if (ov_e && !ovp_e) ovr_e++;
      ovp_n = ov_n;
      ovp_e = ov_e;
   end
   task automatic drive(input logic v, input int n);
      if (sel) ser_e = v; else ser_n = v;
      repeat (n) @(negedge clk);
   endtask
   task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pb, input logic sb, input int gl);
      logic b;
      for (int i = 0; i < 10 + int'(use_par); i++) begin
         b = (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : (use_par && i == 9) ? pb : sb;
         if (i == gl) begin
            drive(b, 7);
            drive(!b, 1);
            drive(b, 8);
         end else drive(b, 16);
      end
      drive(1'b1, 0);
   endtask
   task automatic model_push(input logic [7:0] d, input logic use_par, input logic pb, input logic sb);
      ent_t e;
      e.d  = d;
      e.pe = use_par ? ((^d) ^ pb) : 1'b0;
      e.fe = !sb;
      if (q.size() == DEPTH) exp_ov++;
      else q.push_back(e);
   endtask
   task automatic pop_entry(output logic v, output logic [7:0] d, output logic pe, output logic fe);
      v = s_valid; d = s_data; pe = s_perr; fe = s_ferr;
      if (sel) rdy_e = 1; else rdy_n = 1;
      @(negedge clk);
      rdy_e = 0; rdy_n = 0;
   endtask
   task automatic test_reset;
      sel = 0;
      repeat (3) @(negedge clk);
      cmp++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", s_valid); end
      cmp++; if (s_count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", s_count); end
      cmp++; if ({s_data, s_perr, s_ferr, s_ov} !== 11'd0) begin bad++; $display("FAIL reset_outputs got %h/%b/%b/%b want 0", s_data, s_perr, s_ferr, s_ov); end
      reset = 0;
      drive(1'b1, 20);
   endtask
   task automatic test_basic;
      logic v, pe, fe;
      logic [7:0] d;
      logic [7:0] a5 = 8'hA5;
      sel = 0;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(a5[i], CPB);
      drive(1'b1, 10);
      cmp++; if (s_valid !== 1'b0) begin bad++; $display("FAIL latency_early valid got %b want 0", s_valid); end
      drive(1'b1, 1);
      cmp++; if (s_valid !== 1'b1) begin bad++; $display("FAIL latency valid got %b want 1", s_valid); end
      drive(1'b1, 5);
      pop_entry(v, d, pe, fe);
      cmp++; if ({v, d, pe, fe} !== {1'b1, 8'hA5, 2'b00}) begin bad++; $display("FAIL basic_a5 got v%b %h pe%b fe%b want v1 a5 pe0 fe0", v, d, pe, fe); end
      cmp++; if (s_count !== 3'd0) begin bad++; $display("FAIL basic_drained count %0d want 0", s_count); end
   endtask
   task automatic test_parity;
      logic v, pe, fe;
      logic [7:0] d;
      sel = 1; q.delete();
      send_frame(8'h37, 1, 0, 1, -1); model_push(8'h37, 1, 0, 1);
      send_frame(8'h37, 1, 1, 1, -1); model_push(8'h37, 1, 1, 1);
      drive(1'b1, 4);
      for (int k = 0; k < 2; k++) begin
         pop_entry(v, d, pe, fe);
         cmp++; if ({v, d, pe, fe} !== {1'b1, q[0].d, q[0].pe, q[0].fe}) begin bad++; $display("FAIL parity_%0d got v%b %h pe%b fe%b want %h pe%b fe%b", k, v, d, pe, fe, q[0].d, q[0].pe, q[0].fe); end
         void'(q.pop_front());
      end
   endtask
   task automatic test_frame_glitch;
      logic v, pe, fe;
      logic [7:0] d;
      sel = 0; q.delete();
      send_frame(8'h55, 0, 0, 0, -1); model_push(8'h55, 0, 0, 0);
      drive(1'b1, 32);
      send_frame(8'hFF, 0, 0, 1, 4); model_push(8'hFF, 0, 0, 1);
      send_frame(8'h00, 0, 0, 1, 3); model_push(8'h00, 0, 0, 1);
      drive(1'b1, 4);
      for (int k = 0; k < 3; k++) begin
         pop_entry(v, d, pe, fe);
         cmp++; if ({v, d, pe, fe} !== {1'b1, q[0].d, q[0].pe, q[0].fe}) begin bad++; $display("FAIL frame_glitch_%0d got v%b %h pe%b fe%b want %h pe%b fe%b", k, v, d, pe, fe, q[0].d, q[0].pe, q[0].fe); end
         void'(q.pop_front());
      end
   endtask
   task automatic test_back_to_back;
      logic v, pe, fe;
      logic [7:0] d;
      int h0, r0;
      sel = 0; q.delete(); exp_ov = 0; h0 = ovh_n; r0 = ovr_n;
      for (int k = 1; k <= 6; k++) begin
         send_frame(8'(k), 0, 0, 1, -1);
         model_push(8'(k), 0, 0, 1);
      end
      drive(1'b1, 4);
      cmp++; if (s_count !== 3'(q.size())) begin bad++; $display("FAIL b2b_count got %0d want %0d", s_count, q.size()); end
      cmp++; if (ovh_n - h0 !== exp_ov) begin bad++; $display("FAIL b2b_overrun_cycles got %0d want %0d", ovh_n - h0, exp_ov); end
      cmp++; if (ovr_n - r0 !== exp_ov) begin bad++; $display("FAIL b2b_overrun_pulses got %0d want %0d", ovr_n - r0, exp_ov); end
      drive(1'b1, 20);
      while (q.size() > 0) begin
         pop_entry(v, d, pe, fe);
         cmp++; if ({v, d, pe, fe} !== {1'b1, q[0].d, 2'b00}) begin bad++; $display("FAIL b2b_read got v%b %h pe%b fe%b want %h", v, d, pe, fe, q[0].d); end
         void'(q.pop_front());
      end
      cmp++; if (s_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty valid got %b want 0", s_valid); end
   endtask
   task automatic test_false_start_and_reset;
      logic v, pe, fe;
      logic [7:0] d;
      logic [7:0] c3 = 8'h3C;
      sel = 0;
      drive(1'b0, 4);
      drive(1'b1, 40);
      cmp++; if ({s_valid, s_count} !== 4'd0) begin bad++; $display("FAIL false_start got v%b count %0d want empty", s_valid, s_count); end
      drive(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive(c3[i], CPB);
      drive(c3[3], 8);
      reset = 1;
      drive(1'b1, 3);
      reset = 0;
      drive(1'b1, 40);
      cmp++; if ({s_valid, s_count} !== 4'd0) begin bad++; $display("FAIL reset_midframe got v%b count %0d want empty", s_valid, s_count); end
      send_frame(8'h3C, 0, 0, 1, -1);
      drive(1'b1, 4);
      pop_entry(v, d, pe, fe);
      cmp++; if ({v, d, pe, fe} !== {1'b1, 8'h3C, 2'b00}) begin bad++; $display("FAIL after_reset got v%b %h pe%b fe%b want 3c", v, d, pe, fe); end
   endtask
   task automatic test_random;
      logic v, pe, fe, pb, sb;
      logic [7:0] d, rd;
      int h0, gap;
      sel = 1; q.delete(); exp_ov = 0; h0 = ovh_e;
      for (int n = 0; n < 20; n++) begin
         d = 8'($urandom); pb = 1'($urandom); sb = ($urandom_range(0, 3) != 0);
         gap = $urandom_range(2, 20) + (sb ? 0 : 32);
         send_frame(d, 1, pb, sb, -1);
         model_push(d, 1, pb, sb);
         drive(1'b1, gap);
         cmp++; if (s_count !== 3'(q.size())) begin bad++; $display("FAIL rand_count_%0d got %0d want %0d", n, s_count, q.size()); end
         if ($urandom_range(0, 2) == 0 || n == 19)
            while (q.size() > 0) begin
               pop_entry(v, rd, pe, fe);
               cmp++; if ({v, rd, pe, fe} !== {1'b1, q[0].d, q[0].pe, q[0].fe}) begin bad++; $display("FAIL rand_read_%0d got v%b %h pe%b fe%b want %h pe%b fe%b", n, v, rd, pe, fe, q[0].d, q[0].pe, q[0].fe); end
               void'(q.pop_front());
            end
      end
      cmp++; if (ovh_e - h0 !== exp_ov) begin bad++; $display("FAIL rand_overrun got %0d want %0d", ovh_e - h0, exp_ov); end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_parity;
      test_frame_glitch;
      test_back_to_back;
      test_false_start_and_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
